// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops until both operands are ready,
// captures operands from the writeback broadcast, and issues the oldest ready op.
module alu_rs #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [10:0]       enq_alu_type,
    input  logic              enq_is_word,
    input  logic              enq_is_unsigned,
    input  logic              enq_is_imm,
    input  logic [63:0]       enq_imm,
    input  logic [47:0]       enq_pc,
    input  logic [PREG_W-1:0] enq_prs1,
    input  logic [PREG_W-1:0] enq_prs2,
    input  logic              enq_src1_rdy,
    input  logic              enq_src2_rdy,
    input  logic [63:0]       enq_src1,
    input  logic [63:0]       enq_src2,
    input  logic [PREG_W-1:0] enq_prd,
    input  logic [ROB_W-1:0]  enq_robidx,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_prd,
    input  logic [63:0]       wb_data,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [10:0]       iss_alu_type,
    output logic              iss_is_word,
    output logic              iss_is_unsigned,
    output logic              iss_is_imm,
    output logic [63:0]       iss_src1,
    output logic [63:0]       iss_src2,
    output logic [63:0]       iss_imm,
    output logic [47:0]       iss_pc,
    output logic [PREG_W-1:0] iss_prd,
    output logic [ROB_W-1:0]  iss_robidx
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  rdy1_r;
    logic [DEPTH-1:0]  rdy2_r;
    // older_r[i][j] set means entry i was enqueued before entry j
    logic [DEPTH-1:0]  older_r    [DEPTH];
    logic [10:0]       alu_type_r [DEPTH];
    logic              is_word_r  [DEPTH];
    logic              is_uns_r   [DEPTH];
    logic              is_imm_r   [DEPTH];
    logic [63:0]       imm_r      [DEPTH];
    logic [47:0]       pc_r       [DEPTH];
    logic [PREG_W-1:0] prs1_r     [DEPTH];
    logic [PREG_W-1:0] prs2_r     [DEPTH];
    logic [63:0]       src1_r     [DEPTH];
    logic [63:0]       src2_r     [DEPTH];
    logic [PREG_W-1:0] prd_r      [DEPTH];
    logic [ROB_W-1:0]  robidx_r   [DEPTH];

    logic [DEPTH-1:0]  eligible_s;
    logic [DEPTH-1:0]  blocked_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [IDX_W-1:0]  free_idx_s;
    logic              free_found_s;
    logic              iss_valid_s;
    logic              enq_ready_s;
    logic              iss_fire_s;
    logic              enq_fire_s;
    logic              enq_wake1_s;
    logic              enq_wake2_s;

    assign enq_ready_s = ~(&valid_r);
    assign enq_ready   = enq_ready_s;
    assign iss_valid   = iss_valid_s;
    assign iss_fire_s  = iss_valid_s & iss_ready;
    assign enq_fire_s  = enq_valid & enq_ready_s;
    assign enq_wake1_s = wb_valid & ~enq_src1_rdy & (enq_prs1 == wb_prd);
    assign enq_wake2_s = wb_valid & ~enq_src2_rdy & (enq_prs2 == wb_prd);

    // Lowest-numbered empty slot receives the next dispatched op.
    always_comb begin
        free_idx_s   = '0;
        free_found_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_r[i] && !free_found_s) begin
                free_idx_s   = IDX_W'(i);
                free_found_s = 1'b1;
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Oldest eligible entry: eligible and no other eligible entry is older.
    always_comb begin
        eligible_s  = valid_r & rdy1_r & rdy2_r;
        blocked_s   = '0;
        sel_idx_s   = '0;
        iss_valid_s = |eligible_s;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blocked_s[i] = blocked_s[i] | (eligible_s[j] & older_r[j][i]);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible_s[i] && !blocked_s[i]) begin
                sel_idx_s = IDX_W'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    assign iss_alu_type    = iss_valid_s ? alu_type_r[sel_idx_s] : 11'd0;
    assign iss_is_word     = iss_valid_s ? is_word_r[sel_idx_s]  : 1'b0;
    assign iss_is_unsigned = iss_valid_s ? is_uns_r[sel_idx_s]   : 1'b0;
    assign iss_is_imm      = iss_valid_s ? is_imm_r[sel_idx_s]   : 1'b0;
    assign iss_src1        = iss_valid_s ? src1_r[sel_idx_s]     : 64'd0;
    assign iss_src2        = iss_valid_s ? src2_r[sel_idx_s]     : 64'd0;
    assign iss_imm         = iss_valid_s ? imm_r[sel_idx_s]      : 64'd0;
    assign iss_pc          = iss_valid_s ? pc_r[sel_idx_s]       : 48'd0;
    assign iss_prd         = iss_valid_s ? prd_r[sel_idx_s]      : {PREG_W{1'b0}};
    assign iss_robidx      = iss_valid_s ? robidx_r[sel_idx_s]   : {ROB_W{1'b0}};

    // Entry state update: reset/flush win, otherwise wakeup, issue-free and enqueue.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && wb_valid && !rdy1_r[i] && (prs1_r[i] == wb_prd)) begin
                    rdy1_r[i] <= 1'b1;
                    src1_r[i] <= wb_data;
                end
                if (valid_r[i] && wb_valid && !rdy2_r[i] && (prs2_r[i] == wb_prd)) begin
                    rdy2_r[i] <= 1'b1;
                    src2_r[i] <= wb_data;
                end
            end
            if (iss_fire_s) begin
                valid_r[sel_idx_s] <= 1'b0;
            end
            // A free slot is never the issuing slot, so these writes do not collide.
            if (enq_fire_s) begin
                valid_r[free_idx_s]    <= 1'b1;
                alu_type_r[free_idx_s] <= enq_alu_type;
                is_word_r[free_idx_s]  <= enq_is_word;
                is_uns_r[free_idx_s]   <= enq_is_unsigned;
                is_imm_r[free_idx_s]   <= enq_is_imm;
                imm_r[free_idx_s]      <= enq_imm;
                pc_r[free_idx_s]       <= enq_pc;
                prs1_r[free_idx_s]     <= enq_prs1;
                prs2_r[free_idx_s]     <= enq_prs2;
                rdy1_r[free_idx_s]     <= enq_src1_rdy | enq_wake1_s;
                rdy2_r[free_idx_s]     <= enq_src2_rdy | enq_wake2_s;
                src1_r[free_idx_s]     <= enq_wake1_s ? wb_data : enq_src1;
                src2_r[free_idx_s]     <= enq_wake2_s ? wb_data : enq_src2;
                prd_r[free_idx_s]      <= enq_prd;
                robidx_r[free_idx_s]   <= enq_robidx;
                older_r[free_idx_s]    <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    older_r[j][free_idx_s] <= valid_r[j];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed vector table, hand sequences for ordering/flush/reset,
// then random traffic against an age-ordered queue model.
module tb_alu_rs;
    localparam int DEPTH = 4;

    localparam logic [10:0] C_ALU = 11'h0A5;
    localparam logic [63:0] C_IMM = 64'h0000_0000_0000_DEAD;
    localparam logic [47:0] C_PC  = 48'h0000_0000_1000;
    localparam logic [5:0]  C_PRD = 6'd17;

    logic        clock = 1'b0;
    logic        reset_n, flush, enq_valid, enq_ready;
    logic [10:0] enq_alu_type;
    logic        enq_is_word, enq_is_unsigned, enq_is_imm;
    logic [63:0] enq_imm;
    logic [47:0] enq_pc;
    logic [5:0]  enq_prs1, enq_prs2, enq_prd, enq_robidx;
    logic        enq_src1_rdy, enq_src2_rdy;
    logic [63:0] enq_src1, enq_src2;
    logic        wb_valid;
    logic [5:0]  wb_prd;
    logic [63:0] wb_data;
    logic        iss_valid, iss_ready;
    logic [10:0] iss_alu_type;
    logic        iss_is_word, iss_is_unsigned, iss_is_imm;
    logic [63:0] iss_src1, iss_src2, iss_imm;
    logic [47:0] iss_pc;
    logic [5:0]  iss_prd, iss_robidx;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    alu_rs #(.DEPTH(DEPTH), .PREG_W(6), .ROB_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_alu_type(enq_alu_type), .enq_is_word(enq_is_word),
        .enq_is_unsigned(enq_is_unsigned), .enq_is_imm(enq_is_imm),
        .enq_imm(enq_imm), .enq_pc(enq_pc), .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
        .enq_src1(enq_src1), .enq_src2(enq_src2), .enq_prd(enq_prd),
        .enq_robidx(enq_robidx), .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_alu_type(iss_alu_type),
        .iss_is_word(iss_is_word), .iss_is_unsigned(iss_is_unsigned),
        .iss_is_imm(iss_is_imm), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_prd(iss_prd), .iss_robidx(iss_robidx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic ev; logic [63:0] s1, s2; logic r1, r2; logic [5:0] p1, p2, rob;
        logic wv; logic [5:0] wp; logic [63:0] wd; logic ir;
        logic xer, xiv; logic [63:0] xs1, xs2; logic [5:0] xrob;
    } vec_t;

    typedef struct {
        logic [10:0] alu; logic w, u, im; logic [63:0] imm; logic [47:0] pc;
        logic [5:0] p1, p2; logic r1, r2; logic [63:0] s1, s2; logic [5:0] prd, rob;
    } ent_t;

    ent_t mq[$];
    vec_t tbl [18];

    function automatic vec_t mk(logic ev, logic [63:0] s1, logic [63:0] s2, logic r1, logic r2,
                                logic [5:0] p1, logic [5:0] p2, logic [5:0] rob, logic wv,
                                logic [5:0] wp, logic [63:0] wd, logic ir, logic xer, logic xiv,
                                logic [63:0] xs1, logic [63:0] xs2, logic [5:0] xrob);
        vec_t v;
        v.ev = ev; v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2; v.p1 = p1; v.p2 = p2;
        v.rob = rob; v.wv = wv; v.wp = wp; v.wd = wd; v.ir = ir;
        v.xer = xer; v.xiv = xiv; v.xs1 = xs1; v.xs2 = xs2; v.xrob = xrob;
        return v;
    endfunction

    function automatic logic [267:0] act_vec();
        return {enq_ready, iss_valid, iss_alu_type, iss_is_word, iss_is_unsigned, iss_is_imm,
                iss_src1, iss_src2, iss_imm, iss_pc, iss_prd, iss_robidx};
    endfunction

    // Expected outputs for directed traffic, which always carries the C_* payload.
    function automatic logic [267:0] dir_exp(logic er, logic iv, logic [63:0] s1,
                                             logic [63:0] s2, logic [5:0] rob);
        if (iv)
            return {er, 1'b1, C_ALU, 1'b1, 1'b0, 1'b1, s1, s2, C_IMM, C_PC, C_PRD, rob};
        else
            return {er, 1'b0, 266'd0};
    endfunction

    function automatic logic [267:0] model_expect();
        logic [267:0] e;
        bit found;
        e = {(mq.size() < DEPTH) ? 1'b1 : 1'b0, 1'b0, 266'd0};
        found = 1'b0;
        for (int k = 0; k < mq.size(); k++) begin
            if (!found && mq[k].r1 && mq[k].r2) begin
                found = 1'b1;
                e = {e[267], 1'b1, mq[k].alu, mq[k].w, mq[k].u, mq[k].im, mq[k].s1, mq[k].s2,
                     mq[k].imm, mq[k].pc, mq[k].prd, mq[k].rob};
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        int fire;
        bit accept;
        ent_t n;
        if (!reset_n || flush) begin
            mq.delete();
        end else begin
            fire = -1;
            for (int k = 0; k < mq.size(); k++)
                if (fire < 0 && mq[k].r1 && mq[k].r2) fire = k;
            accept = enq_valid && (mq.size() < DEPTH);
            if (wb_valid) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (!mq[k].r1 && mq[k].p1 == wb_prd) begin mq[k].r1 = 1'b1; mq[k].s1 = wb_data; end
                    if (!mq[k].r2 && mq[k].p2 == wb_prd) begin mq[k].r2 = 1'b1; mq[k].s2 = wb_data; end
                end
            end
            if (iss_ready && fire >= 0) mq.delete(fire);
            if (accept) begin
                n.alu = enq_alu_type; n.w = enq_is_word; n.u = enq_is_unsigned; n.im = enq_is_imm;
                n.imm = enq_imm; n.pc = enq_pc; n.p1 = enq_prs1; n.p2 = enq_prs2;
                n.r1 = enq_src1_rdy; n.r2 = enq_src2_rdy; n.s1 = enq_src1; n.s2 = enq_src2;
                n.prd = enq_prd; n.rob = enq_robidx;
                if (wb_valid && !n.r1 && n.p1 == wb_prd) begin n.r1 = 1'b1; n.s1 = wb_data; end
                if (wb_valid && !n.r2 && n.p2 == wb_prd) begin n.r2 = 1'b1; n.s2 = wb_data; end
                mq.push_back(n);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (model_on) model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [267:0] act, input logic [267:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; enq_valid = 1'b0; wb_valid = 1'b0; wb_prd = 6'd0; wb_data = 64'd0;
        enq_alu_type = C_ALU; enq_is_word = 1'b1; enq_is_unsigned = 1'b0; enq_is_imm = 1'b1;
        enq_imm = C_IMM; enq_pc = C_PC; enq_prd = C_PRD;
        enq_prs1 = 6'd0; enq_prs2 = 6'd0; enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0;
        enq_src1 = 64'd0; enq_src2 = 64'd0; enq_robidx = 6'd0;
    endtask

    task automatic enq(input logic [63:0] s1, input logic [63:0] s2, input logic r1,
                       input logic r2, input logic [5:0] p1, input logic [5:0] p2,
                       input logic [5:0] rob);
        enq_valid = 1'b1; enq_src1 = s1; enq_src2 = s2; enq_src1_rdy = r1; enq_src2_rdy = r2;
        enq_prs1 = p1; enq_prs2 = p2; enq_robidx = rob;
    endtask

    initial begin
        reset_n = 1'b0; iss_ready = 1'b0;
        idle();
        tbl[0]  = mk(1'b1, 64'd5,  64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd3,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b1, 64'd5,      64'd7,  6'd3);
        tbl[1]  = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b0, 64'd0,      64'd0,  6'd0);
        tbl[2]  = mk(1'b1, 64'd0,  64'd2, 1'b0, 1'b1, 6'd9, 6'd0,  6'd4,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b0, 64'd0,      64'd0,  6'd0);
        tbl[3]  = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b0, 64'd0,      64'd0,  6'd0);
        tbl[4]  = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b1, 6'd9,  64'h1234,   1'b1, 1'b1, 1'b1, 64'h1234,   64'd2,  6'd4);
        tbl[5]  = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b0, 64'd0,      64'd0,  6'd0);
        tbl[6]  = mk(1'b1, 64'd10, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd10, 1'b0, 6'd0,  64'd0,      1'b0, 1'b1, 1'b1, 64'd10,     64'd7,  6'd10);
        tbl[7]  = mk(1'b1, 64'd11, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd11, 1'b0, 6'd0,  64'd0,      1'b0, 1'b1, 1'b1, 64'd10,     64'd7,  6'd10);
        tbl[8]  = mk(1'b1, 64'd12, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd12, 1'b0, 6'd0,  64'd0,      1'b0, 1'b1, 1'b1, 64'd10,     64'd7,  6'd10);
        tbl[9]  = mk(1'b1, 64'd13, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd13, 1'b0, 6'd0,  64'd0,      1'b0, 1'b0, 1'b1, 64'd10,     64'd7,  6'd10);
        tbl[10] = mk(1'b1, 64'd14, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd14, 1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b1, 64'd11,     64'd7,  6'd11);
        tbl[11] = mk(1'b1, 64'd14, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0,  6'd14, 1'b0, 6'd0,  64'd0,      1'b0, 1'b0, 1'b1, 64'd11,     64'd7,  6'd11);
        tbl[12] = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b1, 64'd12,     64'd7,  6'd12);
        tbl[13] = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b1, 64'd13,     64'd7,  6'd13);
        tbl[14] = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b1, 64'd14,     64'd7,  6'd14);
        tbl[15] = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b0, 64'd0,      64'd0,  6'd0);
        tbl[16] = mk(1'b1, 64'd3,  64'd0, 1'b1, 1'b0, 6'd0, 6'd33, 6'd20, 1'b1, 6'd33, 64'h55,     1'b0, 1'b1, 1'b1, 64'd3,      64'h55, 6'd20);
        tbl[17] = mk(1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 6'd0, 6'd0,  6'd0,  1'b0, 6'd0,  64'd0,      1'b1, 1'b1, 1'b0, 64'd0,      64'd0,  6'd0);

        tick(); tick();
        reset_n = 1'b1;
        check("reset_state", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));

        for (int r = 0; r < 18; r++) begin
            idle();
            enq_valid = tbl[r].ev;
            enq(tbl[r].s1, tbl[r].s2, tbl[r].r1, tbl[r].r2, tbl[r].p1, tbl[r].p2, tbl[r].rob);
            enq_valid = tbl[r].ev;
            wb_valid = tbl[r].wv; wb_prd = tbl[r].wp; wb_data = tbl[r].wd;
            iss_ready = tbl[r].ir;
            tick();
            check($sformatf("vec%0d", r), act_vec(),
                  dir_exp(tbl[r].xer, tbl[r].xiv, tbl[r].xs1, tbl[r].xs2, tbl[r].xrob));
        end

        // Age order: A waits on p20, B and C ready; A overtakes C once woken.
        idle(); iss_ready = 1'b0;
        enq(64'd0, 64'd7, 1'b0, 1'b1, 6'd20, 6'd0, 6'd1); tick();
        enq(64'd2, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd2); tick();
        enq(64'd3, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd3); tick();
        idle();
        check("age_b_first", act_vec(), dir_exp(1'b1, 1'b1, 64'd2, 64'd7, 6'd2));
        wb_valid = 1'b1; wb_prd = 6'd20; wb_data = 64'hAA; #1;
        check("age_wake_cycle", act_vec(), dir_exp(1'b1, 1'b1, 64'd2, 64'd7, 6'd2));
        tick(); idle();
        check("age_a_oldest", act_vec(), dir_exp(1'b1, 1'b1, 64'hAA, 64'd7, 6'd1));
        iss_ready = 1'b1; tick();
        check("age_then_b", act_vec(), dir_exp(1'b1, 1'b1, 64'd2, 64'd7, 6'd2));
        tick();
        check("age_then_c", act_vec(), dir_exp(1'b1, 1'b1, 64'd3, 64'd7, 6'd3));
        tick();
        check("age_empty", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));

        // Flush beats a concurrent enqueue and wakeup.
        iss_ready = 1'b0;
        enq(64'd5, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd5); tick();
        enq(64'd0, 64'd7, 1'b0, 1'b1, 6'd40, 6'd0, 6'd6); tick();
        enq(64'd7, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd7); tick();
        enq(64'd8, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd8);
        flush = 1'b1; wb_valid = 1'b1; wb_prd = 6'd40; wb_data = 64'hBB;
        tick(); idle();
        check("flush_next", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));
        iss_ready = 1'b1; tick();
        check("flush_retained", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));
        enq(64'd9, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd9); tick(); idle();
        check("flush_reuse", act_vec(), dir_exp(1'b1, 1'b1, 64'd9, 64'd7, 6'd9));
        tick();
        check("flush_reuse_drain", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));

        // Reset mid-operation drops resident entries and ignores inputs.
        iss_ready = 1'b0;
        enq(64'd11, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd11); tick();
        enq(64'd12, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd12); tick();
        idle();
        check("pre_reset", act_vec(), dir_exp(1'b1, 1'b1, 64'd11, 64'd7, 6'd11));
        reset_n = 1'b0; iss_ready = 1'b1; wb_valid = 1'b1;
        enq(64'd13, 64'd7, 1'b1, 1'b1, 6'd0, 6'd0, 6'd13);
        tick(); reset_n = 1'b1; idle();
        check("reset_mid", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));
        tick();
        check("reset_after", act_vec(), dir_exp(1'b1, 1'b0, 64'd0, 64'd0, 6'd0));

        // Random traffic against the queue model, starting from an empty station.
        mq.delete();
        model_on = 1'b1;
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(31, 0) == 0);
            enq_valid = $urandom_range(1, 0);
            enq_alu_type = 11'($urandom); enq_is_word = 1'($urandom);
            enq_is_unsigned = 1'($urandom); enq_is_imm = 1'($urandom);
            enq_imm = {$urandom, $urandom}; enq_pc = 48'({$urandom, $urandom});
            enq_prs1 = 6'($urandom_range(7, 0)); enq_prs2 = 6'($urandom_range(7, 0));
            enq_src1_rdy = ($urandom_range(2, 0) != 0); enq_src2_rdy = ($urandom_range(2, 0) != 0);
            enq_src1 = {$urandom, $urandom}; enq_src2 = {$urandom, $urandom};
            enq_prd = 6'($urandom); enq_robidx = 6'($urandom);
            wb_valid = ($urandom_range(4, 0) < 2); wb_prd = 6'($urandom_range(7, 0));
            wb_data = {$urandom, $urandom};
            iss_ready = $urandom_range(1, 0);
            check($sformatf("rand%0d", c), act_vec(), model_expect());
            tick();
        end
        check("rand_final", act_vec(), model_expect());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
